// File: rtl/float_discriminant_queue_if.sv
// Request/result handshake bundle for the queued FP discriminant engine.
// The master drives requests and result ready; the slave is the engine.
interface float_discriminant_queue_if #(
  parameter int FLEN = 64,
  parameter int ID_W = 4
);
  logic            arg_vld;
  logic            arg_rdy;
  logic [FLEN-1:0] a;
  logic [FLEN-1:0] b;
  logic [FLEN-1:0] c;
  logic            mode;
  logic [ID_W-1:0] arg_id;
  logic            res_vld;
  logic            res_rdy;
  logic [FLEN-1:0] res;
  logic            res_negative;
  logic            err;
  logic [ID_W-1:0] res_id;
  logic            busy;

  modport master (
    output arg_vld, a, b, c, mode, arg_id, res_rdy,
    input  arg_rdy, res_vld, res, res_negative, err, res_id, busy
  );

  modport slave (
    input  arg_vld, a, b, c, mode, arg_id, res_rdy,
    output arg_rdy, res_vld, res, res_negative, err, res_id, busy
  );
endinterface

// File: rtl/float_discriminant_queue.sv
// Queued FP64 discriminant engine: b*b - 4ac or b*b - ac on one shared multiplier
// and one shared subtractor, results returned in order with the request tag.

// Two-stage FP64 multiplier; subnormals flush to zero, round to nearest even.
module f_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_valid,
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic        down_valid,
  output logic [63:0] res,
  output logic        err
);
  logic        vld_p0, vld_p1, err_p1;
  logic [63:0] x_p0, y_p0, res_p1;

  function automatic logic [64:0] round_pack(input logic s, input logic signed [12:0] e_in,
                                             input logic [51:0] frac, input logic g, input logic st);
    logic [52:0]        r;
    logic signed [12:0] e;
    r = {1'b0, frac} + {52'd0, g & (st | frac[0])};
    e = e_in + (r[52] ? 13'sd1 : 13'sd0);
    if (e > 13'sd2046) return {1'b1, 64'd0};
    if (e < 13'sd1)    return {1'b0, s, 63'd0};
    return {1'b0, s, e[10:0], r[51:0]};
  endfunction

  function automatic logic [64:0] fmul(input logic [63:0] p, input logic [63:0] q);
    logic [105:0]       m;
    logic signed [12:0] e;
    logic               s;
    s = p[63] ^ q[63];
    if (&p[62:52] || &q[62:52]) return {1'b1, 64'd0};
    if (p[62:52] == 11'd0 || q[62:52] == 11'd0) return {1'b0, s, 63'd0};
    m = {53'd1, p[51:0]} * {53'd1, q[51:0]};
    e = $signed({2'b00, p[62:52]}) + $signed({2'b00, q[62:52]}) - 13'sd1023;
    if (m[105]) return round_pack(s, e + 13'sd1, m[104:53], m[52], |m[51:0]);
    return round_pack(s, e, m[103:52], m[51], |m[50:0]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= up_valid;
      vld_p1 <= vld_p0;
    end
  end

  // p0: operand capture, p1: product
  always_ff @(posedge clk) begin
    if (up_valid) begin
      x_p0 <= x;
      y_p0 <= y;
    end
    if (vld_p0) {err_p1, res_p1} <= fmul(x_p0, y_p0);
  end

  assign down_valid = vld_p1;
  assign res        = res_p1;
  assign err        = err_p1;
endmodule

// Two-stage FP64 subtractor (x - y); subnormals flush to zero, round to nearest even.
module f_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_valid,
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic        down_valid,
  output logic [63:0] res,
  output logic        err
);
  logic        vld_p0, vld_p1, err_p1;
  logic [63:0] x_p0, y_p0, res_p1;

  function automatic logic [64:0] round_pack(input logic s, input logic signed [12:0] e_in,
                                             input logic [51:0] frac, input logic g, input logic st);
    logic [52:0]        r;
    logic signed [12:0] e;
    r = {1'b0, frac} + {52'd0, g & (st | frac[0])};
    e = e_in + (r[52] ? 13'sd1 : 13'sd0);
    if (e > 13'sd2046) return {1'b1, 64'd0};
    if (e < 13'sd1)    return {1'b0, s, 63'd0};
    return {1'b0, s, e[10:0], r[51:0]};
  endfunction

  function automatic logic [64:0] fsub(input logic [63:0] p, input logic [63:0] q);
    logic [63:0]        qn, l, sm;
    logic [56:0]        ml, ms, sh, acc;
    logic [10:0]        d;
    logic signed [12:0] e;
    if (&p[62:52] || &q[62:52]) return {1'b1, 64'd0};
    qn = {~q[63], q[62:0]};
    if (p[62:0] >= qn[62:0]) begin l = p; sm = qn; end
    else                     begin l = qn; sm = p; end
    // bit 56 catches carry-out, bit 55 is the hidden one, bits 2:0 are guard/round/sticky
    ml  = (l[62:52]  == 11'd0) ? 57'd0 : {2'b01, l[51:0], 3'b000};
    ms  = (sm[62:52] == 11'd0) ? 57'd0 : {2'b01, sm[51:0], 3'b000};
    d   = l[62:52] - sm[62:52];
    sh  = ms >> d;
    ms  = sh | {56'd0, (sh << d) != ms};
    acc = (l[63] == sm[63]) ? ml + ms : ml - ms;
    if (acc == 57'd0) return 65'd0;
    e = $signed({2'b00, l[62:52]});
    if (acc[56]) begin
      acc = {1'b0, acc[56:2], acc[1] | acc[0]};
      e   = e + 13'sd1;
    end else begin
      for (int i = 0; i < 55; i++) begin
        if (!acc[55]) begin
          acc = acc << 1;
          e   = e - 13'sd1;
        end
      end
    end
    return round_pack(l[63], e, acc[54:3], acc[2], |acc[1:0]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= up_valid;
      vld_p1 <= vld_p0;
    end
  end

  // p0: operand capture, p1: difference
  always_ff @(posedge clk) begin
    if (up_valid) begin
      x_p0 <= x;
      y_p0 <= y;
    end
    if (vld_p0) {err_p1, res_p1} <= fsub(x_p0, y_p0);
  end

  assign down_valid = vld_p1;
  assign res        = res_p1;
  assign err        = err_p1;
endmodule

module float_discriminant_queue #(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 4,
  parameter int FLEN       = 64
) (
  input logic                      clk,
  input logic                      rst_n,
  float_discriminant_queue_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3 * FLEN + 1 + ID_W;
  localparam logic [FLEN-1:0] FP_FOUR = FLEN'(64'h4010_0000_0000_0000);

  typedef enum logic [2:0] {IDLE, CHECK, MUL_BB, MUL_AC, MUL_4, SUB, OUT} state_t;

  state_t          state;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            arg_rdy_q, push, pop, bad_exp;
  logic [FLEN-1:0] wa, wb, wc, bb, wres;
  logic            wmode, err_s;
  logic [ID_W-1:0] wid;
  logic            mul_up, mul_dv, mul_err, sub_up, sub_dv, sub_err;
  logic [FLEN-1:0] mul_x, mul_y, mul_res, sub_x, sub_y, sub_res;
  logic            res_vld_q, res_neg_q, err_q;
  logic [FLEN-1:0] res_q;
  logic [ID_W-1:0] res_id_q;

  assign push    = bus.arg_vld & arg_rdy_q;
  assign pop     = (state == IDLE) && (count != '0) && !res_vld_q;
  assign bad_exp = (&wa[FLEN-2:FLEN-12]) | (&wb[FLEN-2:FLEN-12]) | (&wc[FLEN-2:FLEN-12]);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Ready is registered so it reads 0 while reset is held and never depends on a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      arg_rdy_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      arg_rdy_q <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.a, bus.b, bus.c, bus.mode, bus.arg_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err_s     <= 1'b0;
      mul_up    <= 1'b0;
      sub_up    <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
      res_neg_q <= 1'b0;
      res_id_q  <= '0;
    end else begin
      mul_up <= 1'b0;
      sub_up <= 1'b0;
      case (state)
        IDLE:   if (pop) begin err_s <= 1'b0; state <= CHECK; end
        CHECK:  if (bad_exp) begin err_s <= 1'b1; state <= OUT; end
                else begin mul_up <= 1'b1; state <= MUL_BB; end
        MUL_BB: if (mul_dv) begin err_s <= err_s | mul_err; mul_up <= 1'b1; state <= MUL_AC; end
        MUL_AC: if (mul_dv) begin
                  err_s <= err_s | mul_err;
                  if (wmode) begin sub_up <= 1'b1; state <= SUB; end
                  else       begin mul_up <= 1'b1; state <= MUL_4; end
                end
        MUL_4:  if (mul_dv) begin err_s <= err_s | mul_err; sub_up <= 1'b1; state <= SUB; end
        SUB:    if (sub_dv) begin err_s <= err_s | sub_err; state <= OUT; end
        OUT:    if (!res_vld_q) begin
                  res_vld_q <= 1'b1;
                  res_q     <= wres;
                  err_q     <= err_s;
                  res_neg_q <= wres[FLEN-1] & !err_s;
                  res_id_q  <= wid;
                end else if (bus.res_rdy) begin
                  res_vld_q <= 1'b0;
                  state     <= IDLE;
                end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand routing for the shared arithmetic units.
  always_ff @(posedge clk) begin
    if (pop) {wa, wb, wc, wmode, wid} <= mem[rd_ptr];
    case (state)
      CHECK:  begin
                mul_x <= wb;
                mul_y <= wb;
                if (bad_exp) wres <= '0;
              end
      MUL_BB: if (mul_dv) begin bb <= mul_res; mul_x <= wa; mul_y <= wc; end
      MUL_AC: if (mul_dv) begin
                if (wmode) begin sub_x <= bb; sub_y <= mul_res; end
                else       begin mul_x <= mul_res; mul_y <= FP_FOUR; end
              end
      MUL_4:  if (mul_dv) begin sub_x <= bb; sub_y <= mul_res; end
      SUB:    if (sub_dv) wres <= sub_res;
      default: ;
    endcase
  end

  f_mult u_mult (.clk(clk), .rst(~rst_n), .up_valid(mul_up), .x(mul_x), .y(mul_y),
                 .down_valid(mul_dv), .res(mul_res), .err(mul_err));
  f_sub  u_sub  (.clk(clk), .rst(~rst_n), .up_valid(sub_up), .x(sub_x), .y(sub_y),
                 .down_valid(sub_dv), .res(sub_res), .err(sub_err));

  assign bus.arg_rdy      = arg_rdy_q;
  assign bus.res_vld      = res_vld_q;
  assign bus.res          = res_q;
  assign bus.err          = err_q;
  assign bus.res_negative = res_neg_q;
  assign bus.res_id       = res_id_q;
  assign bus.busy         = (count != '0) || (state != IDLE) || res_vld_q;
endmodule

// File: tb/tb_float_discriminant_queue.sv
// Scoreboard bench for float_discriminant_queue: directed FP64 vectors with
// hand-computed discriminants, backpressure, error fast path and mid-run reset.
module tb_float_discriminant_queue;
  localparam logic [63:0] F_ZERO  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] F_ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F_TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F_THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] F_FOUR  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] F_INF   = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] F_QNAN  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] F_BIG   = 64'h7FE0_0000_0000_0000;

  typedef struct packed {
    logic [63:0] res;
    logic        chk_res;
    logic        err;
    logic        neg;
    logic [3:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [63:0] va[6], vb[6], vc[6], vr[6];
  logic        vm[6];

  float_discriminant_queue_if #(.FLEN(64), .ID_W(4)) bus ();
  float_discriminant_queue #(.FIFO_DEPTH(4), .ID_W(4), .FLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic m, input logic [3:0] id, input logic [63:0] er,
                      input logic ee, input logic cr);
    exp_t e;
    logic rdy;
    int   n;
    bus.a = a; bus.b = b; bus.c = c; bus.mode = m; bus.arg_id = id; bus.arg_vld = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 500) begin
      @(negedge clk);
      rdy = bus.arg_rdy;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout: id %0d not accepted after %0d cycles", id, n);
    end else begin
      e.res = er; e.chk_res = cr; e.err = ee; e.neg = er[63] & ~ee & cr; e.id = id;
      exp_q.push_back(e);
    end
    #1 bus.arg_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every accepted result; held output must not move while stalled.
  initial begin : monitor
    logic        held_v;
    logic [63:0] held_res;
    logic [3:0]  held_id;
    exp_t        e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.res_vld) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("stall_res", bus.res, held_res);
          chk("stall_id", 64'(bus.res_id), 64'(held_id));
        end
        if (bus.res_rdy) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got id %0d res %h, required none", bus.res_id, bus.res);
          end else begin
            e = exp_q.pop_front();
            if (e.chk_res) chk("res", bus.res, e.res);
            chk("err", 64'(bus.err), 64'(e.err));
            chk("res_negative", 64'(bus.res_negative), 64'(e.neg));
            chk("res_id", 64'(bus.res_id), 64'(e.id));
          end
        end else begin
          held_v   = 1'b1;
          held_res = bus.res;
          held_id  = bus.res_id;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    va = '{F_ONE,  F_ONE, F_ONE, F_TWO, F_ZERO, F_TWO};
    vb = '{F_FOUR, F_TWO, F_ONE, F_ONE, F_THREE, F_TWO};
    vc = '{F_TWO,  F_ONE, F_ONE, F_TWO, F_ONE,  F_TWO};
    vm = '{1'b0,   1'b1,  1'b0,  1'b1,  1'b0,   1'b1};
    // 16-8=8, 4-1=3, 1-4=-3, 1-4=-3, 9-0=9, 4-4=+0
    vr = '{64'h4020_0000_0000_0000, 64'h4008_0000_0000_0000, 64'hC008_0000_0000_0000,
           64'hC008_0000_0000_0000, 64'h4022_0000_0000_0000, 64'h0000_0000_0000_0000};

    bus.arg_vld = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.mode = 1'b0;
    bus.arg_id = '0; bus.res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arg_rdy", 64'(bus.arg_rdy), 64'd0);
    chk("rst_res_vld", 64'(bus.res_vld), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_res", bus.res, 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arg_rdy_after_rst", 64'(bus.arg_rdy), 64'd1);

    send(F_ONE, F_FOUR, F_TWO, 1'b0, 4'd3, 64'h4020_0000_0000_0000, 1'b0, 1'b1);
    wait_drain("t1");
    send(F_ONE, F_TWO, F_ONE, 1'b1, 4'd1, 64'h4008_0000_0000_0000, 1'b0, 1'b1);
    wait_drain("t2");
    send(F_ONE, F_ONE, F_ONE, 1'b0, 4'd2, 64'hC008_0000_0000_0000, 1'b0, 1'b1);
    wait_drain("t3");
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // Inf operand: one cycle in the FIFO, then two cycles pop-to-valid.
    send(F_ONE, F_INF, F_ONE, 1'b0, 4'd4, 64'd0, 1'b1, 1'b1);
    k = 0;
    while (k < 20) begin
      k++;
      @(posedge clk);
      #1;
      if (bus.res_vld) break;
    end
    chk("fastpath_latency", 64'(k), 64'd3);
    wait_drain("t4");

    send(F_QNAN, F_ONE, F_ONE, 1'b1, 4'd5, 64'd0, 1'b1, 1'b1);
    wait_drain("nan");
    // b*b overflows: sticky error, computation still completes, sign reported as 0
    send(F_ONE, F_BIG, F_ONE, 1'b0, 4'd6, 64'd0, 1'b1, 1'b0);
    wait_drain("ovf");

    bus.res_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(va[i], vb[i], vc[i], vm[i], 4'(i), vr[i], 1'b0, 1'b1);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("full_arg_rdy", 64'(bus.arg_rdy), 64'd0);
        chk("full_busy", 64'(bus.busy), 64'd1);
        chk("full_res_vld", 64'(bus.res_vld), 64'd1);
        bus.res_rdy = 1'b1;
      end
    join
    wait_drain("t5");

    send(va[0], vb[0], vc[0], vm[0], 4'd8, vr[0], 1'b0, 1'b1);
    send(va[1], vb[1], vc[1], vm[1], 4'd9, vr[1], 1'b0, 1'b1);
    send(va[2], vb[2], vc[2], vm[2], 4'd10, vr[2], 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_res_vld", 64'(bus.res_vld), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_arg_rdy", 64'(bus.arg_rdy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_arg_rdy", 64'(bus.arg_rdy), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("postrst_res_vld", 64'(bus.res_vld), 64'd0);
    chk("postrst_busy", 64'(bus.busy), 64'd0);
    send(va[4], vb[4], vc[4], vm[4], 4'd11, vr[4], 1'b0, 1'b1);
    wait_drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
